// File: rtl/frame_tagger.sv
// frame_tagger: cuts a sample stream into overlapping tagged frame bursts.
// Define FRAME_TAGGER_LAST_EN to add the do_last end-of-frame marker.
module frame_tagger #(
    parameter int I_BW      = 14,
    parameter int O_BW      = 14,
    parameter int FRAME_LEN = 1024,
    parameter int HOP_LEN   = 512,
    parameter int ADDR_W    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   di_en,
    input  logic signed [I_BW-1:0] data_i,
    output logic                   do_en,
    output logic signed [O_BW-1:0] data_o,
    output logic [9:0]             out_group_idx,
    output logic [6:0]             out_group_num,
    output logic                   busy,
    output logic                   overflow
`ifdef FRAME_TAGGER_LAST_EN
    ,
    output logic                   do_last
`endif
);

    localparam int FILL_W = ADDR_W + 1;
    localparam logic [FILL_W-1:0] FULL = FILL_W'(FRAME_LEN);
    localparam logic [FILL_W-1:0] HOP  = FILL_W'(HOP_LEN);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                 state;
    logic signed [I_BW-1:0] mem [FRAME_LEN];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      base;
    logic [ADDR_W-1:0]      rd_cnt;
    logic [FILL_W-1:0]      fill;
    logic [6:0]             frame_cnt;
    logic signed [I_BW-1:0] rd_q;
    logic                   wr_ok;
    logic                   last_rd;

    assign wr_ok   = di_en && (fill != FULL);
    assign last_rd = (state == EMIT) && (rd_cnt == LAST);
    assign data_o  = O_BW'($signed(rd_q));

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            base          <= '0;
            rd_cnt        <= '0;
            fill          <= '0;
            frame_cnt     <= '0;
            rd_q          <= '0;
            do_en         <= 1'b0;
            out_group_idx <= '0;
            out_group_num <= '0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
`ifdef FRAME_TAGGER_LAST_EN
            do_last       <= 1'b0;
`endif
        end else begin
            overflow <= di_en && !wr_ok;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            // base only releases HOP_LEN slots once the whole frame is out
            fill  <= fill + FILL_W'(wr_ok) - (last_rd ? HOP : '0);
            do_en <= 1'b0;
`ifdef FRAME_TAGGER_LAST_EN
            do_last <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (fill == FULL) begin
                        state  <= EMIT;
                        rd_cnt <= '0;
                        busy   <= 1'b1;
                    end
                end
                EMIT: begin
                    rd_q          <= mem[base + rd_cnt];
                    do_en         <= 1'b1;
                    out_group_idx <= 10'(rd_cnt);
                    out_group_num <= frame_cnt;
                    rd_cnt        <= rd_cnt + 1'b1;
`ifdef FRAME_TAGGER_LAST_EN
                    do_last       <= (rd_cnt == LAST);
`endif
                    if (rd_cnt == LAST) begin
                        base      <= base + HOP[ADDR_W-1:0];
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_tagger.sv
// tb_frame_tagger: two frame_tagger instances (1024/512 and 16/8) checked
// every cycle against a frame-level model, plus literal burst checks.
`timescale 1ns/1ps
module tb_frame_tagger;

    localparam int DEP = 8192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              den [2];
    logic signed [13:0] din [2];

    logic              do_en0, busy0, ovf0;
    logic signed [15:0] d0;
    logic [9:0]        idx0;
    logic [6:0]        num0;
    logic              do_en1, busy1, ovf1;
    logic signed [13:0] d1;
    logic [9:0]        idx1;
    logic [6:0]        num1;
`ifdef FRAME_TAGGER_LAST_EN
    logic              last0, last1;
`endif

    frame_tagger #(.I_BW(14), .O_BW(16), .FRAME_LEN(1024),
                   .HOP_LEN(512), .ADDR_W(10)) u0 (
        .clk(clk), .rst(rst), .di_en(den[0]), .data_i(din[0]),
        .do_en(do_en0), .data_o(d0), .out_group_idx(idx0),
        .out_group_num(num0), .busy(busy0), .overflow(ovf0)
`ifdef FRAME_TAGGER_LAST_EN
        , .do_last(last0)
`endif
    );

    frame_tagger #(.I_BW(14), .O_BW(14), .FRAME_LEN(16),
                   .HOP_LEN(8), .ADDR_W(4)) u1 (
        .clk(clk), .rst(rst), .di_en(den[1]), .data_i(din[1]),
        .do_en(do_en1), .data_o(d1), .out_group_idx(idx1),
        .out_group_num(num1), .busy(busy1), .overflow(ovf1)
`ifdef FRAME_TAGGER_LAST_EN
        , .do_last(last1)
`endif
    );

    logic              o_en [2], o_busy [2], o_ovf [2], o_last [2];
    logic signed [15:0] o_d [2];
    logic [9:0]        o_idx [2];
    logic [6:0]        o_num [2];
    assign o_en[0] = do_en0;  assign o_en[1] = do_en1;
    assign o_busy[0] = busy0; assign o_busy[1] = busy1;
    assign o_ovf[0] = ovf0;   assign o_ovf[1] = ovf1;
    assign o_d[0] = d0;       assign o_d[1] = {{2{d1[13]}}, d1};
    assign o_idx[0] = idx0;   assign o_idx[1] = idx1;
    assign o_num[0] = num0;   assign o_num[1] = num1;
`ifdef FRAME_TAGGER_LAST_EN
    assign o_last[0] = last0; assign o_last[1] = last1;
`else
    assign o_last[0] = 1'b0;  assign o_last[1] = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: frame k is accepted samples k*hop .. k*hop+fl-1
    int                acc [2], done_n [2], st [2], fr [2];
    bit                act [2];
    logic signed [15:0] ld [2];
    logic signed [15:0] smp [2][DEP];
    int                cyc = 0;

    task automatic step(int u);
        int fl, hop, fill, e_idx;
        bit e_en, e_ovf;
        fl  = (u == 1) ? 16 : 1024;
        hop = (u == 1) ? 8 : 512;
        if (!rst) begin
            acc[u] = 0; done_n[u] = 0; act[u] = 0; ld[u] = '0;
            chk("rst_en", o_en[u], 0);
            chk("rst_data", o_d[u], 0);
            chk("rst_idx", o_idx[u], 0);
            chk("rst_num", o_num[u], 0);
            chk("rst_busy", o_busy[u], 0);
            chk("rst_ovf", o_ovf[u], 0);
`ifdef FRAME_TAGGER_LAST_EN
            chk("rst_last", o_last[u], 0);
`endif
            return;
        end
        fill  = acc[u] - done_n[u] * hop;
        e_en  = 0;
        e_idx = 0;
        if (act[u] && cyc > st[u]) begin
            e_en  = 1;
            e_idx = cyc - st[u] - 1;
            ld[u] = smp[u][(fr[u] * hop + e_idx) % DEP];
        end
        e_ovf = den[u] && (fill == fl);
        if (den[u] && fill < fl) begin
            smp[u][acc[u] % DEP] = din[u];
            acc[u]++;
        end
        if (act[u] && cyc == st[u] + fl) begin
            act[u] = 0;
            done_n[u]++;
        end else if (!act[u] && fill == fl) begin
            act[u] = 1;
            st[u]  = cyc;
            fr[u]  = done_n[u];
        end
        chk("m_en", o_en[u], e_en);
        chk("m_busy", o_busy[u], act[u]);
        chk("m_ovf", o_ovf[u], e_ovf);
        chk("m_data", o_d[u], ld[u]);
        if (e_en) begin
            chk("m_idx", o_idx[u], e_idx);
            chk("m_num", o_num[u], fr[u] % 128);
        end
`ifdef FRAME_TAGGER_LAST_EN
        chk("m_last", o_last[u], e_en && e_idx == fl - 1);
`endif
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        step(0);
        step(1);
    end

    int ovf_cnt = 0;
    bit prev127 = 0;
    bit wrap_seen = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (ovf1) ovf_cnt++;
            if (do_en1 && idx1 == 0) begin
                if (num1 == 0 && prev127) wrap_seen = 1;
                prev127 = (num1 == 127);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed0(int n, int first, bit special);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            den[0] = 1'b1;
            din[0] = 14'(first + i);
            if (special && i == 0) din[0] = 14'(-8192);
            if (special && i == n - 1) din[0] = 14'(8191);
        end
        @(negedge clk);
        den[0] = 1'b0;
    endtask

    task automatic burst0(int num, int dz, int mi, int dm, int dl);
        tick();
        chk("b_busy_t1", busy0, 1);
        chk("b_en_t1", do_en0, 0);
        tick();
        chk("b_en_first", do_en0, 1);
        chk("b_idx_first", idx0, 0);
        chk("b_data_first", d0, dz);
        chk("b_num", num0, num);
        repeat (mi) tick();
        chk("b_idx_mid", idx0, mi);
        chk("b_data_mid", d0, dm);
        repeat (1023 - mi) tick();
        chk("b_en_last", do_en0, 1);
        chk("b_idx_last", idx0, 1023);
        chk("b_data_last", d0, dl);
        chk("b_busy_last", busy0, 0);
`ifdef FRAME_TAGGER_LAST_EN
        chk("b_last", last0, 1);
`endif
        tick();
        chk("b_en_after", do_en0, 0);
    endtask

    task automatic wait_beat0(int idx);
        int n = 0;
        while (!(do_en0 && idx0 == 10'(idx)) && n < 3000) begin
            tick();
            n++;
        end
        chk("wait_beat", n < 3000, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        den[0] = 1'b0; den[1] = 1'b0;
        din[0] = '0;   din[1] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        feed0(1024, 0, 0);
        burst0(0, 0, 300, 300, 1023);

        feed0(512, 1024, 0);
        burst0(1, 512, 300, 812, 1535);

        feed0(512, 1536, 1);
        burst0(2, 1024, 512, -8192, 8191);

        feed0(512, 2048, 0);
        wait_beat0(300);
        #1 rst = 1'b0;
        #1;
        chk("arst_en", do_en0, 0);
        chk("arst_data", d0, 0);
        chk("arst_idx", idx0, 0);
        chk("arst_busy", busy0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        feed0(1023, 100, 0);
        repeat (3) begin
            tick();
            chk("refill_en", do_en0, 0);
            chk("refill_busy", busy0, 0);
        end
        feed0(1, 5000, 0);
        burst0(0, 100, 300, 400, 5000);

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            den[1] = 1'b1;
            din[1] = 14'($urandom);
        end
        chk("ovf_seen", ovf_cnt > 0, 1);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            den[1] = ($urandom_range(0, 7) != 0);
            din[1] = 14'($urandom);
        end
        @(negedge clk);
        den[1] = 1'b0;
        repeat (40) tick();
        chk("num_wrap", wrap_seen, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
